// File: rtl/gpio_input_conditioner.sv
// Front-panel input conditioner: 2-flop synchroniser, prescaled sampling, per-channel
// debounce, sticky rise/fall flags with write-1-to-clear, and a change timestamp.
module gpio_input_conditioner #(
  parameter int N_CH            = 8,
  parameter int SAMPLE_DIV_LOG2 = 16,
  parameter int STABLE_COUNT    = 3,
  parameter int TS_WIDTH        = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     in_raw,
  input  logic [N_CH-1:0]     clr_mask,
  output logic [N_CH-1:0]     in_stable,
  output logic [N_CH-1:0]     rise_flag,
  output logic [N_CH-1:0]     fall_flag,
  output logic                evt_any,
  output logic                sample_tick,
  output logic [TS_WIDTH-1:0] ts_now,
  output logic [TS_WIDTH-1:0] ts_last
);

  localparam int CW = $clog2(STABLE_COUNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);

  logic [N_CH-1:0]            sync1;
  logic [N_CH-1:0]            in_sync;
  logic [SAMPLE_DIV_LOG2-1:0] presc;
  logic [CW-1:0]              cnt      [N_CH];
  logic [CW-1:0]              cnt_next [N_CH];
  logic [N_CH-1:0]            stable_next;
  logic [N_CH-1:0]            change;

  // Debounce decisions are taken only in the cycle where sample_tick is high.
  always_comb begin
    stable_next = in_stable;
    change      = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_next[i] = cnt[i];
      if (sample_tick) begin
        if (in_sync[i] == in_stable[i]) begin
          cnt_next[i] = '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable_next[i] = in_sync[i];
          change[i]      = 1'b1;
          cnt_next[i]    = '0;
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= '0;
      in_sync     <= '0;
      presc       <= '0;
      sample_tick <= 1'b0;
      in_stable   <= '0;
      rise_flag   <= '0;
      fall_flag   <= '0;
      ts_now      <= '0;
      ts_last     <= '0;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      sync1       <= in_raw;
      in_sync     <= sync1;
      presc       <= presc + 1'b1;
      sample_tick <= &presc;
      in_stable   <= stable_next;
      ts_now      <= ts_now + 1'b1;
      for (int i = 0; i < N_CH; i++) cnt[i] <= cnt_next[i];
      // A new event overrides a clear landing on the same bit.
      rise_flag <= (rise_flag & ~clr_mask) | (change & in_sync);
      fall_flag <= (fall_flag & ~clr_mask) | (change & ~in_sync);
      if (|change) ts_last <= ts_now;
    end
  end

  assign evt_any = |(rise_flag | fall_flag);

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner with a 4-cycle sample period and
// 3-sample debounce; edge-relative timing is tracked by a cycle counter from reset release.
module tb_gpio_input_conditioner;

  localparam int N_CH = 4;
  localparam int SDL  = 2;
  localparam int SC   = 3;
  localparam int TSW  = 8;

  logic            clk;
  logic            rst;
  logic [N_CH-1:0] in_raw;
  logic [N_CH-1:0] clr_mask;
  logic [N_CH-1:0] in_stable;
  logic [N_CH-1:0] rise_flag;
  logic [N_CH-1:0] fall_flag;
  logic            evt_any;
  logic            sample_tick;
  logic [TSW-1:0]  ts_now;
  logic [TSW-1:0]  ts_last;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  gpio_input_conditioner #(
    .N_CH(N_CH), .SAMPLE_DIV_LOG2(SDL), .STABLE_COUNT(SC), .TS_WIDTH(TSW)
  ) dut (
    .clk(clk), .rst(rst), .in_raw(in_raw), .clr_mask(clr_mask),
    .in_stable(in_stable), .rise_flag(rise_flag), .fall_flag(fall_flag),
    .evt_any(evt_any), .sample_tick(sample_tick), .ts_now(ts_now), .ts_last(ts_last)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard-style checker: every comparison goes through here.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock edge; cyc counts edges since reset release. Tick and timestamp
  // are checked on every edge against their closed-form expectations.
  task automatic step();
    logic r;
    logic exp_tick;
    r = rst;
    @(posedge clk);
    #1;
    if (r) cyc = 0;
    else   cyc++;
    exp_tick = !r && (cyc >= 4) && (cyc % 4 == 0);
    check("sample_tick", 32'(sample_tick), 32'(exp_tick));
    check("ts_now", 32'(ts_now), r ? 32'd0 : 32'(cyc % 256));
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic check_state(input string tag, input logic [3:0] e_stable,
                             input logic [3:0] e_rise, input logic [3:0] e_fall);
    check({tag, ".in_stable"}, 32'(in_stable), 32'(e_stable));
    check({tag, ".rise_flag"}, 32'(rise_flag), 32'(e_rise));
    check({tag, ".fall_flag"}, 32'(fall_flag), 32'(e_fall));
    check({tag, ".evt_any"},   32'(evt_any),   32'(|(e_rise | e_fall)));
  endtask

  initial begin
    rst      = 1'b1;
    in_raw   = '0;
    clr_mask = '0;
    repeat (3) step();
    check_state("reset", 4'b0000, 4'b0000, 4'b0000);
    check("reset.ts_last", 32'(ts_last), 32'd0);
    rst = 1'b0;

    // 1: idle inputs, ticks at 4, 8, 12; nothing changes
    run_to(12);
    check_state("idle", 4'b0000, 4'b0000, 4'b0000);

    // 2: ch0 rises; in_sync at 14, ticks 16/20/24, update on edge 25
    in_raw[0] = 1'b1;
    run_to(24);
    check_state("ch0_pre", 4'b0000, 4'b0000, 4'b0000);
    run_to(25);
    check_state("ch0_rise", 4'b0001, 4'b0001, 4'b0000);
    check("ch0_rise.ts_last", 32'(ts_last), 32'd24);

    // 3: ch1 high for ticks 32/36, low at tick 40, high for ticks 44/48/52
    run_to(28);
    in_raw[1] = 1'b1;
    run_to(38);
    in_raw[1] = 1'b0;
    run_to(41);
    in_raw[1] = 1'b1;
    check_state("ch1_glitch", 4'b0001, 4'b0001, 4'b0000);
    run_to(52);
    check_state("ch1_pre", 4'b0001, 4'b0001, 4'b0000);
    run_to(53);
    check_state("ch1_rise", 4'b0011, 4'b0011, 4'b0000);
    check("ch1_rise.ts_last", 32'(ts_last), 32'd52);

    // 4: ch0 falls on edge 69 while clr_mask[0] is pulsed on the same edge
    run_to(56);
    in_raw[0] = 1'b0;
    run_to(68);
    check_state("ch0_fall_pre", 4'b0011, 4'b0011, 4'b0000);
    clr_mask = 4'b0001;
    step();
    clr_mask = 4'b0000;
    check_state("set_wins", 4'b0010, 4'b0010, 4'b0001);
    check("set_wins.ts_last", 32'(ts_last), 32'd68);
    step();
    clr_mask = 4'b0011;
    step();
    clr_mask = 4'b0000;
    check_state("clear", 4'b0010, 4'b0000, 4'b0000);

    // 5: ch2 and ch3 rise together (ticks 244/248/252), then ts_now wraps at 256
    run_to(240);
    in_raw[3:2] = 2'b11;
    run_to(252);
    check_state("ch23_pre", 4'b0010, 4'b0000, 4'b0000);
    run_to(253);
    check_state("ch23_rise", 4'b1110, 4'b1100, 4'b0000);
    check("ch23_rise.ts_last", 32'(ts_last), 32'd252);
    run_to(260);
    check("wrap.ts_last", 32'(ts_last), 32'd252);
    check_state("wrap", 4'b1110, 4'b1100, 4'b0000);

    // 6: ch0 rising again, reset after two counted ticks (268, 272)
    run_to(264);
    in_raw[0] = 1'b1;
    run_to(274);
    check_state("ch0_partial", 4'b1110, 4'b1100, 4'b0000);
    rst = 1'b1;
    repeat (3) step();
    check_state("mid_reset", 4'b0000, 4'b0000, 4'b0000);
    check("mid_reset.ts_last", 32'(ts_last), 32'd0);
    rst = 1'b0;
    run_to(12);
    check_state("post_reset_pre", 4'b0000, 4'b0000, 4'b0000);
    run_to(13);
    check_state("post_reset_rise", 4'b1111, 4'b1111, 4'b0000);
    check("post_reset.ts_last", 32'(ts_last), 32'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
